// File: rtl/stream_top_i64_i64.sv
// Streaming kernel: one start token launches two independent i64 generators
// (S0, S1). Each emits COUNT elements, an EOS beat, and a completion token;
// a final outCtrl token closes the invocation and the block re-arms.
// Optional macro STREAM_TOP_PROTOCOL_CHECK_EN compiles in simulation-only
// protocol checks; when undefined no checking logic exists.

module stream_top_gen #(
  parameter logic [31:0] COUNT = 32'd4,
  parameter logic [63:0] START = 64'd0,
  parameter logic [63:0] STEP  = 64'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic        clear_i,
  output logic        beatValid_o,
  input  logic        beatReady_i,
  output logic [63:0] beatData_o,
  output logic        beatEos_o,
  output logic        tokValid_o,
  input  logic        tokReady_i,
  output logic        fin_o
);
  localparam logic [2:0] G_IDLE = 3'd0;
  localparam logic [2:0] G_ELEM = 3'd1;
  localparam logic [2:0] G_EOS  = 3'd2;
  localparam logic [2:0] G_TOK  = 3'd3;
  localparam logic [2:0] G_FIN  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [63:0] value_q, value_d;
  logic [31:0] remain_q, remain_d;
  logic        beatFire, tokFire;

  assign beatValid_o = (state_q == G_ELEM) || (state_q == G_EOS);
  assign beatEos_o   = (state_q == G_EOS);
  assign beatData_o  = (state_q == G_ELEM) ? value_q : 64'd0;
  assign tokValid_o  = (state_q == G_TOK);
  assign fin_o       = (state_q == G_FIN);
  assign beatFire    = beatValid_o && beatReady_i;
  assign tokFire     = tokValid_o && tokReady_i;

  // Next-state: walk elements, EOS, token, then park until the top clears us
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    remain_d = remain_q;
    case (state_q)
      G_IDLE: if (start_i) begin
        value_d  = START;
        remain_d = COUNT;
        state_d  = (COUNT == 32'd0) ? G_EOS : G_ELEM;
      end
      G_ELEM: if (beatFire) begin
        value_d  = value_q + STEP;
        remain_d = remain_q - 32'd1;
        if (remain_q == 32'd1) state_d = G_EOS;
      end
      G_EOS:  if (beatFire) state_d = G_TOK;
      G_TOK:  if (tokFire) state_d = G_FIN;
      G_FIN:  if (clear_i) begin
        value_d  = START;
        remain_d = COUNT;
        state_d  = G_IDLE;
      end
      default: state_d = G_IDLE;
    endcase
  end

  // Generator registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= G_IDLE;
      value_q  <= START;
      remain_q <= COUNT;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      remain_q <= remain_d;
    end
  end

`ifdef STREAM_TOP_PROTOCOL_CHECK_EN
  logic [31:0] seen_q;
  logic        stalled_q;
  logic        tokStalled_q;
  logic [64:0] held_q;
  logic        eosDone_q;

  // Simulation-only checks: stability, element count before EOS, silence after EOS
  always_ff @(posedge clock) begin
    if (!reset) begin
      seen_q       <= 32'd0;
      stalled_q    <= 1'b0;
      tokStalled_q <= 1'b0;
      held_q       <= 65'd0;
      eosDone_q    <= 1'b0;
    end else begin
      if (stalled_q && (!beatValid_o || ({beatEos_o, beatData_o} != held_q)))
        $error("stream beat changed while stalled");
      if (tokStalled_q && !tokValid_o)
        $error("completion token dropped while stalled");
      if (beatFire && eosDone_q)
        $error("beat after EOS");
      if (beatFire && beatEos_o && (seen_q != COUNT))
        $error("EOS after %0d elements, expected %0d", seen_q, COUNT);
      stalled_q    <= beatValid_o && !beatReady_i;
      tokStalled_q <= tokValid_o && !tokReady_i;
      held_q       <= {beatEos_o, beatData_o};
      if (start_i) begin
        seen_q    <= 32'd0;
        eosDone_q <= 1'b0;
      end else if (beatFire) begin
        if (beatEos_o) eosDone_q <= 1'b1;
        else           seen_q    <= seen_q + 32'd1;
      end
    end
  end
`else
  // No protocol checking in this build.
`endif
endmodule

module stream_top_i64_i64 #(
  parameter logic [31:0] S0_COUNT = 32'd4,
  parameter logic [63:0] S0_START = 64'd0,
  parameter logic [63:0] S0_STEP  = 64'd1,
  parameter logic [31:0] S1_COUNT = 32'd3,
  parameter logic [63:0] S1_START = 64'd100,
  parameter logic [63:0] S1_STEP  = 64'd10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inCtrl_valid,
  output logic        inCtrl_ready,
  output logic        out0_valid,
  input  logic        out0_ready,
  output logic [63:0] out0_data_field0,
  output logic        out0_data_field1,
  output logic        out1_valid,
  input  logic        out1_ready,
  output logic        out2_valid,
  input  logic        out2_ready,
  output logic [63:0] out2_data_field0,
  output logic        out2_data_field1,
  output logic        out3_valid,
  input  logic        out3_ready,
  output logic        outCtrl_valid,
  input  logic        outCtrl_ready
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic       inFire, outFire, fin0, fin1;

  assign inCtrl_ready  = (state_q == IDLE);
  assign outCtrl_valid = (state_q == DONE);
  assign inFire        = inCtrl_valid && inCtrl_ready;
  assign outFire       = outCtrl_valid && outCtrl_ready;

  stream_top_gen #(.COUNT(S0_COUNT), .START(S0_START), .STEP(S0_STEP)) gen0 (
    .clock(clock), .reset(reset), .start_i(inFire), .clear_i(outFire),
    .beatValid_o(out0_valid), .beatReady_i(out0_ready),
    .beatData_o(out0_data_field0), .beatEos_o(out0_data_field1),
    .tokValid_o(out1_valid), .tokReady_i(out1_ready), .fin_o(fin0)
  );

  stream_top_gen #(.COUNT(S1_COUNT), .START(S1_START), .STEP(S1_STEP)) gen1 (
    .clock(clock), .reset(reset), .start_i(inFire), .clear_i(outFire),
    .beatValid_o(out2_valid), .beatReady_i(out2_ready),
    .beatData_o(out2_data_field0), .beatEos_o(out2_data_field1),
    .tokValid_o(out3_valid), .tokReady_i(out3_ready), .fin_o(fin1)
  );

  // Top sequencing: accept start, wait for both generators, hand back done token
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inFire) state_d = RUN;
      RUN:     if (fin0 && fin1) state_d = DONE;
      DONE:    if (outFire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Top state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef STREAM_TOP_PROTOCOL_CHECK_EN
  logic doneStalled_q;

  // Simulation-only checks on the control channels
  always_ff @(posedge clock) begin
    if (!reset) begin
      doneStalled_q <= 1'b0;
    end else begin
      if ((state_q != IDLE) && inCtrl_ready)
        $error("inCtrl_ready high outside IDLE");
      if (doneStalled_q && !outCtrl_valid)
        $error("outCtrl_valid dropped while stalled");
      doneStalled_q <= outCtrl_valid && !outCtrl_ready;
    end
  end
`else
  // No protocol checking in this build.
`endif
endmodule

// File: tb/tb_stream_top_i64_i64.sv
// Self-checking bench for stream_top_i64_i64: three instances cover default
// parameters, a zero-length S0 and a wrapping S1; expected beats come from
// start + idx*step arithmetic.

module tb_stream_top_i64_i64;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  // Default-parameter instance
  logic aInV, aInR, a0v, a0r, a0e, a1v, a1r, a2v, a2r, a2e, a3v, a3r, acv, acr;
  logic [63:0] a0d, a2d;
  // S0_COUNT = 0 instance
  logic zInV, zInR, z0v, z0r, z0e, z1v, z1r, z2v, z2r, z2e, z3v, z3r, zcv, zcr;
  logic [63:0] z0d, z2d;
  // Wrapping S1 instance
  logic wInV, wInR, w0v, w0r, w0e, w1v, w1r, w2v, w2r, w2e, w3v, w3r, wcv, wcr;
  logic [63:0] w0d, w2d;

  localparam logic [63:0] WRAP_START = 64'hFFFF_FFFF_FFFF_FFFB;

  stream_top_i64_i64 dutA (
    .clock(clock), .reset(reset), .inCtrl_valid(aInV), .inCtrl_ready(aInR),
    .out0_valid(a0v), .out0_ready(a0r), .out0_data_field0(a0d), .out0_data_field1(a0e),
    .out1_valid(a1v), .out1_ready(a1r),
    .out2_valid(a2v), .out2_ready(a2r), .out2_data_field0(a2d), .out2_data_field1(a2e),
    .out3_valid(a3v), .out3_ready(a3r), .outCtrl_valid(acv), .outCtrl_ready(acr)
  );

  stream_top_i64_i64 #(.S0_COUNT(32'd0)) dutZ (
    .clock(clock), .reset(reset), .inCtrl_valid(zInV), .inCtrl_ready(zInR),
    .out0_valid(z0v), .out0_ready(z0r), .out0_data_field0(z0d), .out0_data_field1(z0e),
    .out1_valid(z1v), .out1_ready(z1r),
    .out2_valid(z2v), .out2_ready(z2r), .out2_data_field0(z2d), .out2_data_field1(z2e),
    .out3_valid(z3v), .out3_ready(z3r), .outCtrl_valid(zcv), .outCtrl_ready(zcr)
  );

  stream_top_i64_i64 #(.S1_COUNT(32'd2), .S1_START(WRAP_START), .S1_STEP(64'd10)) dutW (
    .clock(clock), .reset(reset), .inCtrl_valid(wInV), .inCtrl_ready(wInR),
    .out0_valid(w0v), .out0_ready(w0r), .out0_data_field0(w0d), .out0_data_field1(w0e),
    .out1_valid(w1v), .out1_ready(w1r),
    .out2_valid(w2v), .out2_ready(w2r), .out2_data_field0(w2d), .out2_data_field1(w2e),
    .out3_valid(w3v), .out3_ready(w3r), .outCtrl_valid(wcv), .outCtrl_ready(wcr)
  );

  // Reference: beat idx of a stream is start + idx*step, or EOS once idx reaches count
  function automatic logic [64:0] expBeat(input int count, input logic [63:0] start,
                                          input logic [63:0] step, input int idx);
    if (idx < count) return {1'b0, start + 64'(idx) * step};
    return {1'b1, 64'd0};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    aInV = 0; zInV = 0; wInV = 0;
    a0r = 1; a1r = 1; a2r = 1; a3r = 1; acr = 1;
    z0r = 1; z1r = 1; z2r = 1; z3r = 1; zcr = 1;
    w0r = 1; w1r = 1; w2r = 1; w3r = 1; wcr = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if ({a0v, a1v, a2v, a3v, acv, aInR} !== 6'b000001 || a0d !== 64'd0 || a2d !== 64'd0 ||
          {a0e, a2e} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_idle_A got v=%b%b%b%b%b rdy=%b d0=%h d2=%h exp valids=0 rdy=1 data=0",
                 a0v, a1v, a2v, a3v, acv, aInR, a0d, a2d);
      end
      checks++;
      if ({z0v, z2v, zcv, zInR, w0v, w2v, wcv, wInR} !== 8'b00010001) begin
        failures++;
        $display("[TB] FAIL reset_idle_ZW got z=%b%b%b%b w=%b%b%b%b exp 0001 0001",
                 z0v, z2v, zcv, zInR, w0v, w2v, wcv, wInR);
      end
    end
  endtask

  // mode 0: all ready; 1: random readies; 2: out0 stalled for first 10 cycles
  task automatic test_stream(input int mode);
    int  idx0 = 0, idx1 = 0;
    bit  tok0 = 0, tok1 = 0, done = 0, st0 = 0, st1 = 0;
    logic [64:0] held0 = '0, held1 = '0;
    @(negedge clock);
    checks++;
    if (aInR !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_ready mode%0d got=%b exp=1", mode, aInR);
    end
    aInV = 1;
    @(negedge clock);
    aInV = 0;
    checks++;
    if (a0v !== 1'b1 || a2v !== 1'b1) begin
      failures++;
      $display("[TB] FAIL first_beat_latency mode%0d got v0=%b v2=%b exp 1 1", mode, a0v, a2v);
    end
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (st0) begin
        checks++;
        if (a0v !== 1'b1 || {a0e, a0d} !== held0) begin
          failures++;
          $display("[TB] FAIL s0_stable mode%0d got v=%b %h exp v=1 %h", mode, a0v, {a0e, a0d}, held0);
        end
      end
      if (st1) begin
        checks++;
        if (a2v !== 1'b1 || {a2e, a2d} !== held1) begin
          failures++;
          $display("[TB] FAIL s1_stable mode%0d got v=%b %h exp v=1 %h", mode, a2v, {a2e, a2d}, held1);
        end
      end
      if (a0v) begin
        checks++;
        if (idx0 > 4 || {a0e, a0d} !== expBeat(4, 64'd0, 64'd1, idx0)) begin
          failures++;
          $display("[TB] FAIL s0_beat mode%0d idx=%0d got=%h exp=%h", mode, idx0, {a0e, a0d},
                   expBeat(4, 64'd0, 64'd1, idx0));
        end
      end
      if (a2v) begin
        checks++;
        if (idx1 > 3 || {a2e, a2d} !== expBeat(3, 64'd100, 64'd10, idx1)) begin
          failures++;
          $display("[TB] FAIL s1_beat mode%0d idx=%0d got=%h exp=%h", mode, idx1, {a2e, a2d},
                   expBeat(3, 64'd100, 64'd10, idx1));
        end
      end
      if (a1v) begin
        checks++;
        if (idx0 != 5 || tok0) begin
          failures++;
          $display("[TB] FAIL s0_token_order mode%0d got beats=%0d tok=%0d exp beats=5 tok=0", mode, idx0, tok0);
        end
      end
      if (a3v) begin
        checks++;
        if (idx1 != 4 || tok1) begin
          failures++;
          $display("[TB] FAIL s1_token_order mode%0d got beats=%0d tok=%0d exp beats=4 tok=0", mode, idx1, tok1);
        end
      end
      if (acv) begin
        checks++;
        if (!(tok0 && tok1)) begin
          failures++;
          $display("[TB] FAIL done_order mode%0d got tok0=%0d tok1=%0d exp 1 1", mode, tok0, tok1);
        end
      end
      checks++;
      if (aInR !== 1'b0) begin
        failures++;
        $display("[TB] FAIL run_ready mode%0d got=%b exp=0", mode, aInR);
      end
      if (mode == 2 && cyc == 10) begin
        checks++;
        if (idx1 != 4 || !tok1 || idx0 != 0 || acv !== 1'b0) begin
          failures++;
          $display("[TB] FAIL s1_independent got s1beats=%0d tok1=%0d s0beats=%0d done=%b exp 4 1 0 0",
                   idx1, tok1, idx0, acv);
        end
      end
      // choose readies for this cycle; extra start tokens must stall
      if (mode == 0) begin
        a0r = 1; a1r = 1; a2r = 1; a3r = 1; acr = 1;
      end else if (mode == 1) begin
        a0r = $urandom_range(0, 1); a1r = $urandom_range(0, 1); a2r = $urandom_range(0, 1);
        a3r = $urandom_range(0, 1); acr = $urandom_range(0, 1);
      end else begin
        a0r = (cyc >= 10); a1r = 1; a2r = 1; a3r = 1; acr = 1;
      end
      aInV = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (acv && acr) aInV = 0;
      st0 = a0v && !a0r; held0 = {a0e, a0d};
      st1 = a2v && !a2r; held1 = {a2e, a2d};
      if (a0v && a0r) idx0++;
      if (a2v && a2r) idx1++;
      if (a1v && a1r) tok0 = 1;
      if (a3v && a3r) tok1 = 1;
      if (acv && acr) done = 1;
    end
    checks++;
    if (!done || idx0 != 5 || idx1 != 4 || !tok0 || !tok1) begin
      failures++;
      $display("[TB] FAIL complete mode%0d got done=%0d b0=%0d b1=%0d t0=%0d t1=%0d exp 1 5 4 1 1",
               mode, done, idx0, idx1, tok0, tok1);
    end
    aInV = 0; a0r = 1; a1r = 1; a2r = 1; a3r = 1; acr = 1;
    @(negedge clock);
    checks++;
    if (aInR !== 1'b1 || {a0v, a1v, a2v, a3v, acv} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL rearm mode%0d got rdy=%b valids=%b%b%b%b%b exp rdy=1 valids=0",
               mode, aInR, a0v, a1v, a2v, a3v, acv);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clock);
    aInV = 1;
    @(negedge clock);
    aInV = 0;
    repeat (2) @(negedge clock);
    checks++;
    if (a0v !== 1'b1 || a0d !== 64'd2) begin
      failures++;
      $display("[TB] FAIL pre_reset_s0 got v=%b d=%0d exp v=1 d=2", a0v, a0d);
    end
    reset = 1'b0;
    aInV = 1;
    @(negedge clock);
    checks++;
    if ({a0v, a1v, a2v, a3v, acv} !== 5'b0 || a0d !== 64'd0 || a2d !== 64'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_drop got valids=%b%b%b%b%b d0=%h d2=%h exp 0",
               a0v, a1v, a2v, a3v, acv, a0d, a2d);
    end
    reset = 1'b1;
    aInV = 0;
    @(negedge clock);
    checks++;
    if (aInR !== 1'b1 || a0v !== 1'b0 || a2v !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_wins_start got rdy=%b v0=%b v2=%b exp 1 0 0", aInR, a0v, a2v);
    end
  endtask

  task automatic test_zero_count();
    int  i0 = 0, i1 = 0;
    bit  done = 0;
    @(negedge clock);
    zInV = 1;
    @(negedge clock);
    zInV = 0;
    checks++;
    if (z0v !== 1'b1 || z0e !== 1'b1 || z0d !== 64'd0) begin
      failures++;
      $display("[TB] FAIL zero_first_eos got v=%b e=%b d=%h exp 1 1 0", z0v, z0e, z0d);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clock);
      if (z0v) begin
        checks++;
        if (i0 > 0 || {z0e, z0d} !== expBeat(0, 64'd0, 64'd1, i0)) begin
          failures++;
          $display("[TB] FAIL zero_s0 idx=%0d got=%h exp=%h", i0, {z0e, z0d}, expBeat(0, 64'd0, 64'd1, i0));
        end
        i0++;
      end
      if (z2v) begin
        checks++;
        if (i1 > 3 || {z2e, z2d} !== expBeat(3, 64'd100, 64'd10, i1)) begin
          failures++;
          $display("[TB] FAIL zero_s1 idx=%0d got=%h exp=%h", i1, {z2e, z2d}, expBeat(3, 64'd100, 64'd10, i1));
        end
        i1++;
      end
      if (zcv) done = 1;
    end
    checks++;
    if (!done || i0 != 1 || i1 != 4) begin
      failures++;
      $display("[TB] FAIL zero_complete got done=%0d b0=%0d b1=%0d exp 1 1 4", done, i0, i1);
    end
    @(negedge clock);
    checks++;
    if (zInR !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_rearm got=%b exp=1", zInR);
    end
  endtask

  task automatic test_wrap();
    int  i0 = 0, i1 = 0;
    bit  done = 0;
    @(negedge clock);
    wInV = 1;
    @(negedge clock);
    wInV = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clock);
      if (w0v) begin
        checks++;
        if (i0 > 4 || {w0e, w0d} !== expBeat(4, 64'd0, 64'd1, i0)) begin
          failures++;
          $display("[TB] FAIL wrap_s0 idx=%0d got=%h exp=%h", i0, {w0e, w0d}, expBeat(4, 64'd0, 64'd1, i0));
        end
        i0++;
      end
      if (w2v) begin
        checks++;
        if (i1 > 2 || {w2e, w2d} !== expBeat(2, WRAP_START, 64'd10, i1)) begin
          failures++;
          $display("[TB] FAIL wrap_s1 idx=%0d got=%h exp=%h", i1, {w2e, w2d}, expBeat(2, WRAP_START, 64'd10, i1));
        end
        if (i1 == 1) begin
          checks++;
          if (w2d !== 64'd5) begin
            failures++;
            $display("[TB] FAIL wrap_value got=%0d exp=5", w2d);
          end
        end
        i1++;
      end
      if (wcv) done = 1;
    end
    checks++;
    if (!done || i0 != 5 || i1 != 3) begin
      failures++;
      $display("[TB] FAIL wrap_complete got done=%0d b0=%0d b1=%0d exp 1 5 3", done, i0, i1);
    end
  endtask

  initial begin
    test_reset();
    test_stream(0);
    test_stream(2);
    test_stream(1);
    test_stream(1);
    test_mid_reset();
    test_stream(0);
    test_zero_count();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
